bus_io_fifo_port: RTL

- I/O-mapped byte mailbox peripheral on the demultiplexed 8088 bus, downstream of the 8282 address latch and 8286 transceiver.
- Decodes 8088 I/O bus cycles (IOM=1) against a base port.
- CPU writes push into a TX FIFO, which drains to a device-side valid/ready stream.
- A device-side stream fills an RX FIFO, which CPU reads pop. A status register is exposed at BASE+1.

---
 rtl/bus_io_fifo_port_pkg.sv | 36 +++
 rtl/bus_io_fifo_port_if.sv | 26 ++
 rtl/bus_io_fifo_port_sync_fifo.sv | 58 +++++
 rtl/bus_io_fifo_port.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/bus_io_fifo_port_pkg.sv
// Shared types and constants for the bus_io_fifo_port I/O mailbox.
// Bus FSM states, register selects and status-byte layout.
package bus_io_fifo_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ADDR  = 2'd1,
      READ  = 2'd2,
      WRITE = 2'd3
   } bus_state_e;

   localparam logic REG_DATA   = 1'b0;
   localparam logic REG_STATUS = 1'b1;

   localparam int ST_RX_NONEMPTY  = 0;
   localparam int ST_TX_EMPTY     = 1;
   localparam int ST_TX_OVERFLOW  = 2;
   localparam int ST_RX_UNDERFLOW = 3;
   localparam int ST_INTR         = 7;

   function automatic logic [7:0] status_byte(input logic intr,
                                              input logic rx_underflow,
                                              input logic tx_overflow,
                                              input logic tx_empty,
                                              input logic rx_nonempty);
      logic [7:0] s;
      s                  = 8'h00;
      s[ST_INTR]         = intr;
      s[ST_RX_UNDERFLOW] = rx_underflow;
      s[ST_TX_OVERFLOW]  = tx_overflow;
      s[ST_TX_EMPTY]     = tx_empty;
      s[ST_RX_NONEMPTY]  = rx_nonempty;
      return s;
   endfunction

endpackage

// File: rtl/bus_io_fifo_port_if.sv
// Demultiplexed 8088 bus controls plus the device-side TX/RX streams.
// The tristate Data bus stays a plain inout on the top module.
interface bus_io_fifo_port_if;
   logic        ALE;
   logic        IOM;
   logic        RD;
   logic        WR;
   logic        DEN;
   logic [19:0] Address;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;

   modport master (
      output ALE, IOM, RD, WR, DEN, Address, tx_ready, rx_data, rx_valid,
      input  tx_data, tx_valid, rx_ready
   );

   modport slave (
      input  ALE, IOM, RD, WR, DEN, Address, tx_ready, rx_data, rx_valid,
      output tx_data, tx_valid, rx_ready
   );
endinterface

// File: rtl/bus_io_fifo_port_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; DEPTH must be a power of two.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CW'(do_push) - CW'(do_pop);
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; occupancy alone defines what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end
endmodule

// File: rtl/bus_io_fifo_port.sv
// I/O-mapped byte mailbox on the 8088 bus: data port at BASE_ADDR, status at BASE_ADDR+1.
// Define BUS_IO_FIFO_PORT_IRQ_EN to add the registered INTR output and status bit 7.
module bus_io_fifo_port
   import bus_io_fifo_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR = 16'h0400,
   parameter int          DEPTH     = 8
) (
   input  logic                 CLK,
   input  logic                 RESET_N,
   bus_io_fifo_port_if.slave    bus,
   inout  wire  [7:0]           Data
`ifdef BUS_IO_FIFO_PORT_IRQ_EN
   , output logic               INTR
`endif
);
   localparam int CW = $clog2(DEPTH) + 1;

   bus_state_e state_q, state_d;
   logic       sel_q, reg_q;
   logic [7:0] rd_byte_q, wr_byte_q;
   logic       tx_overflow_q, rx_underflow_q;
   logic       intr_bit;

   logic       match, drive_en;
   logic       read_exit, write_exit;
   logic       tx_push, tx_pop, tx_full, tx_empty;
   logic       rx_push, rx_pop, rx_full, rx_empty;
   logic       ovf_set, und_set, flags_clr;
   logic [7:0] rx_head, status;
   logic [CW-1:0] tx_count, rx_count;
   logic       unused_sigs;

   assign unused_sigs = ^{bus.Address[19:16], tx_count, rx_count};

   assign match  = bus.IOM & (bus.Address[15:1] == BASE_ADDR[15:1]);
   assign status = status_byte(intr_bit, rx_underflow_q, tx_overflow_q, tx_empty, ~rx_empty);

   assign tx_pop       = bus.tx_valid & bus.tx_ready;
   assign rx_push      = bus.rx_valid & bus.rx_ready;
   assign bus.tx_valid = ~tx_empty;
   assign bus.rx_ready = ~rx_full;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (bus.ALE && match) state_d = ADDR;
         ADDR: begin
            if (!sel_q)        state_d = IDLE;
            else if (!bus.RD)  state_d = READ;
            else if (!bus.WR)  state_d = WRITE;
            else if (bus.ALE)  state_d = match ? ADDR : IDLE;
         end
         READ:  if (bus.RD) state_d = IDLE;
         WRITE: if (bus.WR) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Strobe-release edges carry every FIFO and flag side effect of a bus cycle.
   always_comb begin
      read_exit  = (state_q == READ)  && bus.RD;
      write_exit = (state_q == WRITE) && bus.WR;
      drive_en   = (state_q == READ)  && !bus.RD && !bus.DEN;
      rx_pop     = read_exit && (reg_q == REG_DATA) && !rx_empty;
      und_set    = read_exit && (reg_q == REG_DATA) && rx_empty;
      flags_clr  = read_exit && (reg_q == REG_STATUS);
      tx_push    = write_exit && (reg_q == REG_DATA);
      ovf_set    = tx_push && tx_full && !tx_pop;
   end

   assign Data = drive_en ? rd_byte_q : 8'hzz;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         sel_q          <= 1'b0;
         reg_q          <= REG_DATA;
         rd_byte_q      <= 8'h00;
         wr_byte_q      <= 8'h00;
         tx_overflow_q  <= 1'b0;
         rx_underflow_q <= 1'b0;
      end else begin
         if (bus.ALE && (state_q == IDLE || state_q == ADDR)) begin
            sel_q <= match;
            reg_q <= bus.Address[0];
         end
         if (state_q == ADDR && sel_q && !bus.RD)
            rd_byte_q <= (reg_q == REG_STATUS) ? status : (rx_empty ? 8'h00 : rx_head);
         if (state_q == WRITE && !bus.WR && !bus.DEN)
            wr_byte_q <= Data;
         if (flags_clr) begin
            tx_overflow_q  <= 1'b0;
            rx_underflow_q <= 1'b0;
         end else begin
            if (ovf_set) tx_overflow_q  <= 1'b1;
            if (und_set) rx_underflow_q <= 1'b1;
         end
      end
   end

`ifdef BUS_IO_FIFO_PORT_IRQ_EN
   logic intr_q;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) intr_q <= 1'b0;
      else          intr_q <= ~rx_empty | tx_overflow_q;
   end

   assign INTR     = intr_q;
   assign intr_bit = intr_q;
`else
   assign intr_bit = 1'b0;
`endif

   sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
      .clk     (CLK),
      .rst_n   (RESET_N),
      .push_i  (tx_push),
      .wdata_i (wr_byte_q),
      .pop_i   (tx_pop),
      .rdata_o (bus.tx_data),
      .full_o  (tx_full),
      .empty_o (tx_empty),
      .count_o (tx_count)
   );

   sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
      .clk     (CLK),
      .rst_n   (RESET_N),
      .push_i  (rx_push),
      .wdata_i (bus.rx_data),
      .pop_i   (rx_pop),
      .rdata_o (rx_head),
      .full_o  (rx_full),
      .empty_o (rx_empty),
      .count_o (rx_count)
   );
endmodule
